if_id_stage: RTL and testbench

- Fetch stage and IF/ID pipeline register of the 5-stage RV32I core.
- Owns the PC and drives the instruction-memory address. Registers the fetched instruction into ID.
- Sits directly upstream of the hazard control unit, which decodes the registered instruction.
- Consumes that unit's Flush (taken branch) plus a decode-side Stall; holds or squashes the IF/ID contents accordingly.
- Saturating flush and stall counters are included for performance debug.

---
 rtl/if_id_stage_if.sv | 27 ++
 rtl/if_id_stage.sv | 112 +++++++++++
 tb/tb_if_id_stage.sv | 139 +++++++++++++
 3 files changed

// File: rtl/if_id_stage_if.sv
// Fetch-stage bus: hazard controls, instruction-memory port and IF/ID register outputs.
// master = the fetch stage, slave = hazard unit / imem / decode side.
interface if_id_stage_if #(
  parameter int CNT_W = 16
);
  logic             Stall;
  logic             Flush;
  logic [31:0]      BranchTarget;
  logic [31:0]      ImemData;
  logic [31:0]      ImemAddr;
  logic [31:0]      InstrID;
  logic [31:0]      PCID;
  logic [31:0]      PC4ID;
  logic             ValidID;
  logic [CNT_W-1:0] FlushCnt;
  logic [CNT_W-1:0] StallCnt;

  modport master (
    input  Stall, Flush, BranchTarget, ImemData,
    output ImemAddr, InstrID, PCID, PC4ID, ValidID, FlushCnt, StallCnt
  );

  modport slave (
    output Stall, Flush, BranchTarget, ImemData,
    input  ImemAddr, InstrID, PCID, PC4ID, ValidID, FlushCnt, StallCnt
  );
endinterface

// File: rtl/if_id_stage.sv
// PC owner and IF/ID register; instruction at ImemAddr lands in ID one edge later.
// Stall freezes PC and IF/ID, Flush redirects and squashes (Flush wins over Stall).
module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 16
) (
  input  logic          clk,
  input  logic          rst,
  if_id_stage_if.master bus
);

  typedef enum logic {BOOT, FETCH} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
  } ifIdReg_t;

  state_t           stateQ, stateNext;
  logic [31:0]      pcQ, pcNext, pcPlus4, redirectPc;
  ifIdReg_t         ifIdQ, ifIdNext;
  logic             flushInc, stallInc;
  logic [CNT_W-1:0] flushCntQ, stallCntQ;

  assign pcPlus4    = pcQ + 32'd4;
  assign redirectPc = bus.BranchTarget & ~32'h0000_0003;

  // State register
  always_ff @(posedge clk) begin
    if (rst) stateQ <= BOOT;
    else     stateQ <= stateNext;
  end

  // Next-state logic: BOOT lasts exactly one cycle
  always_comb begin
    stateNext = stateQ;
    case (stateQ)
      BOOT:    stateNext = FETCH;
      FETCH:   stateNext = FETCH;
      default: stateNext = BOOT;
    endcase
  end

  // Output logic: next PC, next IF/ID contents and counter increments
  always_comb begin
    pcNext   = pcQ;
    ifIdNext = ifIdQ;
    flushInc = 1'b0;
    stallInc = 1'b0;
    case (stateQ)
      BOOT: begin
        ifIdNext.instr = NOP_INSTR;
        ifIdNext.valid = 1'b0;
        if (bus.Flush) begin
          pcNext   = redirectPc;
          flushInc = 1'b1;
        end
      end
      FETCH: begin
        if (bus.Flush) begin
          // Squash keeps the old PCID/PC4ID; only instr and valid change
          pcNext         = redirectPc;
          ifIdNext.instr = NOP_INSTR;
          ifIdNext.valid = 1'b0;
          flushInc       = 1'b1;
        end else if (bus.Stall) begin
          stallInc = 1'b1;
        end else begin
          pcNext         = pcPlus4;
          ifIdNext.instr = bus.ImemData;
          ifIdNext.pc    = pcQ;
          ifIdNext.pc4   = pcPlus4;
          ifIdNext.valid = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcQ   <= RESET_PC;
      ifIdQ <= '{instr: NOP_INSTR, pc: 32'd0, pc4: 32'd0, valid: 1'b0};
    end else begin
      pcQ   <= pcNext;
      ifIdQ <= ifIdNext;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      flushCntQ <= '0;
      stallCntQ <= '0;
    end else begin
      if (flushInc && (flushCntQ != '1)) flushCntQ <= flushCntQ + 1'b1;
      if (stallInc && (stallCntQ != '1)) stallCntQ <= stallCntQ + 1'b1;
    end
  end

  assign bus.ImemAddr = pcQ;
  assign bus.InstrID  = ifIdQ.instr;
  assign bus.PCID     = ifIdQ.pc;
  assign bus.PC4ID    = ifIdQ.pc4;
  assign bus.ValidID  = ifIdQ.valid;
  assign bus.FlushCnt = flushCntQ;
  assign bus.StallCnt = stallCntQ;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: stimulus pushes hand-computed post-edge state, monitor pops and checks.
module tb_if_id_stage;
  localparam int CNT_W = 4;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pcid;
    logic [31:0] pc4;
    logic        valid;
    int          fc;
    int          sc;
  } expT;

  logic clk = 1'b0;
  logic rst;
  expT  expQ[$];
  int   testsRun = 0;
  int   testsFailed = 0;

  if_id_stage_if #(.CNT_W(CNT_W)) bus ();

  if_id_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0013),
    .CNT_W    (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Instruction memory: word 0 is a real addi, others tag their own address
  function automatic logic [31:0] imem(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {a[23:0], 8'h13};
  endfunction

  assign bus.ImemData = imem(bus.ImemAddr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    testsRun++;
    if (act !== req) begin
      testsFailed++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic f, input logic [31:0] tgt,
                      input logic [31:0] a, input logic [31:0] i, input logic [31:0] p,
                      input logic [31:0] p4, input logic v, input int fc, input int sc);
    expT e;
    @(negedge clk);
    rst = r;
    bus.Stall = s;
    bus.Flush = f;
    bus.BranchTarget = tgt;
    e = '{addr: a, instr: i, pcid: p, pc4: p4, valid: v, fc: fc, sc: sc};
    expQ.push_back(e);
    @(posedge clk);
  endtask

  // Monitor: outputs are always presented, so one expectation per edge
  always @(posedge clk) begin
    expT e;
    #1;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      chk("ImemAddr", bus.ImemAddr, e.addr);
      chk("InstrID",  bus.InstrID,  e.instr);
      chk("PCID",     bus.PCID,     e.pcid);
      chk("PC4ID",    bus.PC4ID,    e.pc4);
      chk("ValidID",  {31'd0, bus.ValidID}, {31'd0, e.valid});
      chk("FlushCnt", {28'd0, bus.FlushCnt}, e.fc);
      chk("StallCnt", {28'd0, bus.StallCnt}, e.sc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.Stall = 1'b0;
    bus.Flush = 1'b0;
    bus.BranchTarget = 32'h0;

    // Reset and boot
    step(1, 0, 0, 0, 32'h0, 32'h13, 32'h0, 32'h0, 0, 0, 0);
    step(1, 0, 0, 0, 32'h0, 32'h13, 32'h0, 32'h0, 0, 0, 0);
    step(0, 1, 0, 0, 32'h0, 32'h13, 32'h0, 32'h0, 0, 0, 0);            // BOOT ignores Stall
    step(0, 0, 0, 0, 32'h4, 32'h0050_0093, 32'h0, 32'h4, 1, 0, 0);
    // Sequential fetch
    step(0, 0, 0, 0, 32'h8, 32'h0000_0413, 32'h4, 32'h8, 1, 0, 0);
    step(0, 0, 0, 0, 32'hC, 32'h0000_0813, 32'h8, 32'hC, 1, 0, 0);
    // Stall x3 with PCID=8
    step(0, 1, 0, 0, 32'hC, 32'h0000_0813, 32'h8, 32'hC, 1, 0, 1);
    step(0, 1, 0, 0, 32'hC, 32'h0000_0813, 32'h8, 32'hC, 1, 0, 2);
    step(0, 1, 0, 0, 32'hC, 32'h0000_0813, 32'h8, 32'hC, 1, 0, 3);
    step(0, 0, 0, 0, 32'h10, 32'h0000_0C13, 32'hC, 32'h10, 1, 0, 3);
    step(0, 0, 0, 0, 32'h14, 32'h0000_1013, 32'h10, 32'h14, 1, 0, 3);
    // Flush to 0x103 -> 0x100
    step(0, 0, 1, 32'h103, 32'h100, 32'h13, 32'h10, 32'h14, 0, 1, 3);
    step(0, 0, 0, 0, 32'h104, 32'h0001_0013, 32'h100, 32'h104, 1, 1, 3);
    // Flush + Stall together
    step(0, 1, 1, 32'h200, 32'h200, 32'h13, 32'h100, 32'h104, 0, 2, 3);
    step(0, 0, 0, 0, 32'h204, 32'h0002_0013, 32'h200, 32'h204, 1, 2, 3);
    // Back-to-back flushes, last one wraps around the top of memory
    step(0, 0, 1, 32'h300, 32'h300, 32'h13, 32'h200, 32'h204, 0, 3, 3);
    step(0, 0, 1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h13, 32'h200, 32'h204, 0, 4, 3);
    step(0, 0, 0, 0, 32'h0, 32'hFFFF_FC13, 32'hFFFF_FFFC, 32'h0, 1, 4, 3);
    step(0, 0, 0, 0, 32'h4, 32'h0050_0093, 32'h0, 32'h4, 1, 4, 3);
    // 17 more stalls (20 total) saturate StallCnt at 15
    for (int i = 1; i <= 17; i++)
      step(0, 1, 0, 0, 32'h4, 32'h0050_0093, 32'h0, 32'h4, 1, 4, (3 + i > 15) ? 15 : 3 + i);
    // 12 flushes saturate FlushCnt at 15
    for (int i = 1; i <= 12; i++)
      step(0, 0, 1, 32'h40, 32'h40, 32'h13, 32'h0, 32'h4, 0, (4 + i > 15) ? 15 : 4 + i, 15);
    // Reset mid-stall with Flush also high
    step(0, 1, 0, 0, 32'h40, 32'h13, 32'h0, 32'h4, 0, 15, 15);
    step(1, 1, 1, 32'h80, 32'h0, 32'h13, 32'h0, 32'h0, 0, 0, 0);
    step(0, 1, 0, 0, 32'h0, 32'h13, 32'h0, 32'h0, 0, 0, 0);
    step(0, 0, 0, 0, 32'h4, 32'h0050_0093, 32'h0, 32'h4, 1, 0, 0);
    // Flush taken during BOOT
    step(1, 0, 0, 0, 32'h0, 32'h13, 32'h0, 32'h0, 0, 0, 0);
    step(0, 0, 1, 32'h11, 32'h10, 32'h13, 32'h0, 32'h0, 0, 1, 0);
    step(0, 0, 0, 0, 32'h14, 32'h0000_1013, 32'h10, 32'h14, 1, 1, 0);

    @(negedge clk);
    chk("queue_drained", expQ.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
